// File: rtl/axi_mem_rr_arbiter.sv
// Round-robin arbiter that shares one single-port SRAM among N memory controllers.
// It issues at most one access per cycle and routes read data back to the owner one cycle later.
module axi_mem_rr_arbiter #(
    parameter int N_PORTS        = 2,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int DATA_WIDTH     = 64,
    parameter int BE_WIDTH       = DATA_WIDTH / 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [N_PORTS-1:0]                       req_valid_i,
    input  logic [N_PORTS-1:0]                       req_wen_i,
    input  logic [N_PORTS-1:0][MEM_ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]       req_wdata_i,
    input  logic [N_PORTS-1:0][BE_WIDTH-1:0]         req_be_i,
    output logic [N_PORTS-1:0]                       grant_o,
    output logic [N_PORTS-1:0]                       rvalid_o,
    output logic [DATA_WIDTH-1:0]                    rdata_o,
    input  logic                                     mem_stall_i,
    output logic                                     MEM_CEN_o,
    output logic                                     MEM_WEN_o,
    output logic [MEM_ADDR_WIDTH-1:0]                MEM_A_o,
    output logic [DATA_WIDTH-1:0]                    MEM_D_o,
    output logic [BE_WIDTH-1:0]                      MEM_BE_o,
    input  logic [DATA_WIDTH-1:0]                    MEM_Q_i
);

    localparam int PTR_W = (N_PORTS > 2) ? $clog2(N_PORTS) : 1;

    logic [PTR_W-1:0]   prio_ptr_q, prio_ptr_d;
    logic [N_PORTS-1:0] rd_owner_q, rd_owner_d;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   cand;
    logic               win_found;
    logic               grant_en;
    int                 idx;

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        cand      = '0;
        idx       = 0;
        // Scan from the priority pointer upward, wrapping modulo N_PORTS; the first requester wins.
        for (int i = 0; i < N_PORTS; i++) begin
            idx = int'(prio_ptr_q) + i;
            if (idx >= N_PORTS) begin
                idx = idx - N_PORTS;
            end
            cand = PTR_W'(idx);
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                winner    = cand;
            end
        end
    end

    assign grant_en = win_found && !mem_stall_i && !rst;

    always_comb begin
        grant_o    = '0;
        prio_ptr_d = prio_ptr_q;
        MEM_CEN_o  = 1'b1;
        MEM_WEN_o  = 1'b1;
        MEM_A_o    = '0;
        MEM_D_o    = '0;
        MEM_BE_o   = '0;
        if (grant_en) begin
            grant_o[winner] = 1'b1;
            prio_ptr_d      = (int'(winner) == N_PORTS - 1) ? '0 : winner + 1'b1;
            MEM_CEN_o       = 1'b0;
            MEM_WEN_o       = req_wen_i[winner];
            MEM_A_o         = req_addr_i[winner];
            MEM_D_o         = req_wdata_i[winner];
            MEM_BE_o        = req_be_i[winner];
        end
    end

    // Only reads expect data back; a write grant leaves no owner.
    assign rd_owner_d = grant_o & req_wen_i;
    assign rvalid_o   = rd_owner_q;
    assign rdata_o    = MEM_Q_i;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_ptr_q <= '0;
            rd_owner_q <= '0;
        end else begin
            prio_ptr_q <= prio_ptr_d;
            rd_owner_q <= rd_owner_d;
        end
    end

endmodule

// File: tb/tb_axi_mem_rr_arbiter.sv
// Directed bench for axi_mem_rr_arbiter: a driver queues expected pins and read returns,
// and negedge monitors pop and compare them against a 2-port and a 3-port instance.
`timescale 1ns/1ps
module tb_axi_mem_rr_arbiter;

    typedef struct {
        logic [1:0]  grant;
        logic        cen;
        logic        wen;
        logic [15:0] addr;
        logic [63:0] d;
        logic [7:0]  be;
    } cyc_exp_t;

    typedef struct {
        int          cyc;
        logic [1:0]  port;
        logic [63:0] data;
    } rd_exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_wen = '1;
    logic [1:0][15:0] req_addr = '0;
    logic [1:0][63:0] req_wdata = '0;
    logic [1:0][7:0]  req_be = '0;
    logic             mem_stall = 1'b0;
    logic [1:0]       grant, rvalid;
    logic [63:0]      rdata;
    logic             mem_cen, mem_wen;
    logic [15:0]      mem_a;
    logic [63:0]      mem_d;
    logic [7:0]       mem_be;
    logic [63:0]      mem_q;

    logic [2:0]       v3 = '0;
    logic [2:0]       wen3 = '1;
    logic [2:0][15:0] addr3 = '0;
    logic [2:0][63:0] wdata3 = '0;
    logic [2:0][7:0]  be3 = '0;
    logic [2:0]       grant3, rvalid3;
    logic [63:0]      rdata3;
    logic             cen3, mwen3;
    logic [15:0]      a3;
    logic [63:0]      d3;
    logic [7:0]       mbe3;
    logic [63:0]      q3 = '0;

    logic [63:0]      mem [0:255];
    int               cyc = 0;
    int               n_vec = 0;
    int               n_err = 0;
    cyc_exp_t         exp_cyc[$];
    rd_exp_t          exp_rd[$];
    logic [2:0]       exp3[$];

    axi_mem_rr_arbiter #(.N_PORTS(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_wen_i(req_wen), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_be_i(req_be),
        .grant_o(grant), .rvalid_o(rvalid), .rdata_o(rdata),
        .mem_stall_i(mem_stall),
        .MEM_CEN_o(mem_cen), .MEM_WEN_o(mem_wen), .MEM_A_o(mem_a),
        .MEM_D_o(mem_d), .MEM_BE_o(mem_be), .MEM_Q_i(mem_q)
    );

    axi_mem_rr_arbiter #(.N_PORTS(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid_i(v3), .req_wen_i(wen3), .req_addr_i(addr3),
        .req_wdata_i(wdata3), .req_be_i(be3),
        .grant_o(grant3), .rvalid_o(rvalid3), .rdata_o(rdata3),
        .mem_stall_i(1'b0),
        .MEM_CEN_o(cen3), .MEM_WEN_o(mwen3), .MEM_A_o(a3),
        .MEM_D_o(d3), .MEM_BE_o(mbe3), .MEM_Q_i(q3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port SRAM with byte enables and one-cycle read latency.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 64'(i * 8);
    end

    always @(posedge clk) begin
        if (!mem_cen) begin
            if (!mem_wen) begin
                for (int b = 0; b < 8; b++)
                    if (mem_be[b]) mem[mem_a[7:0]][b*8 +: 8] <= mem_d[b*8 +: 8];
            end else begin
                mem_q <= mem[mem_a[7:0]];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of requests and queue what the DUT must show for it.
    task automatic step(input logic [1:0] v, input logic [1:0] wn, input logic st,
                        input logic [1:0] eg, input logic [63:0] erd, input bit ret = 1'b1);
        cyc_exp_t e;
        rd_exp_t  r;
        int       w;
        req_valid = v;
        req_wen   = wn;
        mem_stall = st;
        w = eg[1] ? 1 : 0;
        e.grant = eg;
        if (eg != 2'b00) begin
            e.cen  = 1'b0;
            e.wen  = wn[w];
            e.addr = req_addr[w];
            e.d    = req_wdata[w];
            e.be   = req_be[w];
        end else begin
            e.cen  = 1'b1;
            e.wen  = 1'b1;
            e.addr = '0;
            e.d    = '0;
            e.be   = '0;
        end
        exp_cyc.push_back(e);
        if (eg != 2'b00 && wn[w] && ret) begin
            r.cyc  = cyc + 1;
            r.port = eg;
            r.data = erd;
            exp_rd.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input logic [2:0] v, input logic [2:0] eg);
        v3 = v;
        exp3.push_back(eg);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_grant"},  64'(grant),  64'd0);
        check({tag, "_rvalid"}, 64'(rvalid), 64'd0);
        check({tag, "_cen"},    64'(mem_cen), 64'd1);
        check({tag, "_wen"},    64'(mem_wen), 64'd1);
        check({tag, "_addr"},   64'(mem_a),  64'd0);
        check({tag, "_wdata"},  mem_d,       64'd0);
        check({tag, "_be"},     64'(mem_be), 64'd0);
        check({tag, "_rdata"},  rdata,       mem_q);
        check({tag, "_grant3"}, 64'(grant3), 64'd0);
    endtask

    // Monitor: per-cycle pin expectations and read returns, decoupled from the driver.
    always @(negedge clk) begin
        cyc_exp_t e;
        rd_exp_t  r;
        if (!rst) begin
            if (exp_cyc.size() > 0) begin
                e = exp_cyc.pop_front();
                check("grant",    64'(grant),   64'(e.grant));
                check("mem_cen",  64'(mem_cen), 64'(e.cen));
                check("mem_wen",  64'(mem_wen), 64'(e.wen));
                check("mem_addr", 64'(mem_a),   64'(e.addr));
                check("mem_d",    mem_d,        e.d);
                check("mem_be",   64'(mem_be),  64'(e.be));
            end
            if (exp_rd.size() > 0 && exp_rd[0].cyc == cyc) begin
                r = exp_rd.pop_front();
                check("rvalid", 64'(rvalid), 64'(r.port));
                check("rdata",  rdata,       r.data);
            end else begin
                check("rvalid_idle", 64'(rvalid), 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && exp3.size() > 0) check("grant3", 64'(grant3), 64'(exp3.pop_front()));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        // Reset: outputs forced to idle even with requests pending.
        repeat (2) @(posedge clk);
        #1;
        req_valid = 2'b11;
        v3 = 3'b111;
        @(negedge clk);
        reset_check("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 2'b00;
        v3 = 3'b000;

        // Single port reading back-to-back, word[i] = i*8.
        req_addr[1] = 16'h0010; step(2'b10, 2'b11, 1'b0, 2'b10, 64'h80);
        req_addr[1] = 16'h0011; step(2'b10, 2'b11, 1'b0, 2'b10, 64'h88);
        req_addr[1] = 16'h0012; step(2'b10, 2'b11, 1'b0, 2'b10, 64'h90);
        step(2'b00, 2'b11, 1'b0, 2'b00, 64'h0);

        // Contention: port 0 reads, port 1 writes; grants alternate from port 0.
        req_addr[0] = 16'h0020; req_addr[1] = 16'h0030;
        req_wdata[1] = 64'h1111; req_be[1] = 8'hFF;
        step(2'b11, 2'b01, 1'b0, 2'b01, 64'h100);
        req_addr[0] = 16'h0021;
        step(2'b11, 2'b01, 1'b0, 2'b10, 64'h0);
        req_addr[1] = 16'h0031;
        step(2'b11, 2'b01, 1'b0, 2'b01, 64'h108);
        req_addr[0] = 16'h0022;
        step(2'b11, 2'b01, 1'b0, 2'b10, 64'h0);
        req_addr[1] = 16'h0032;
        step(2'b11, 2'b01, 1'b0, 2'b01, 64'h110);
        step(2'b11, 2'b01, 1'b0, 2'b10, 64'h0);
        step(2'b00, 2'b11, 1'b0, 2'b00, 64'h0);

        // Stall right after a read grant: data still returns, pointer frozen at 1.
        req_addr[0] = 16'h0005;
        step(2'b01, 2'b11, 1'b0, 2'b01, 64'h28);
        req_addr[0] = 16'h0007; req_addr[1] = 16'h0006;
        repeat (3) step(2'b11, 2'b11, 1'b1, 2'b00, 64'h0);
        step(2'b11, 2'b11, 1'b0, 2'b10, 64'h30);
        step(2'b01, 2'b11, 1'b0, 2'b01, 64'h38);
        step(2'b00, 2'b11, 1'b0, 2'b00, 64'h0);

        // Write then read, full and partial byte enables.
        req_addr[1] = 16'h0042; req_wdata[1] = 64'hDEADBEEF_CAFEF00D; req_be[1] = 8'hFF;
        step(2'b10, 2'b01, 1'b0, 2'b10, 64'h0);
        req_addr[0] = 16'h0042;
        step(2'b01, 2'b01, 1'b0, 2'b01, 64'hDEADBEEF_CAFEF00D);
        req_addr[1] = 16'h0043; req_wdata[1] = 64'hFFFFFFFF_12345678; req_be[1] = 8'h0F;
        step(2'b10, 2'b01, 1'b0, 2'b10, 64'h0);
        req_addr[0] = 16'h0043;
        step(2'b01, 2'b01, 1'b0, 2'b01, 64'h00000000_12345678);
        step(2'b00, 2'b11, 1'b0, 2'b00, 64'h0);

        // Three ports: pointer to 1, then port 2 wins and the pointer wraps to port 0.
        step3(3'b001, 3'b001);
        step3(3'b101, 3'b100);
        step3(3'b101, 3'b001);
        step3(3'b100, 3'b100);
        step3(3'b100, 3'b100);
        step3(3'b000, 3'b000);

        // Reset with a read in flight: the return is dropped, port 0 wins after release.
        req_addr[0] = 16'h0050;
        step(2'b01, 2'b11, 1'b0, 2'b01, 64'h0, 1'b0);
        rst = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        reset_check("rst_flight");
        @(posedge clk);
        #1;
        @(negedge clk);
        reset_check("rst_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_addr[1] = 16'h0060;
        step(2'b11, 2'b11, 1'b0, 2'b01, 64'h280);
        step(2'b11, 2'b11, 1'b0, 2'b10, 64'h300);
        step(2'b00, 2'b11, 1'b0, 2'b00, 64'h0);
        step(2'b00, 2'b11, 1'b0, 2'b00, 64'h0);

        check("pending_reads", 64'(exp_rd.size()), 64'd0);
        check("pending_cycles", 64'(exp_cyc.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
